serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_adder.sv | 17 +
 rtl/serial_adder.sv | 135 +++++++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
`timescale 1ns/1ps
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell shared by every bit position of the serial adder.
`timescale 1ns/1ps
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum is the parity of the three inputs, carry is their majority.
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are captured on a valid/ready
// handshake, then summed LSB-first one bit per clock through one full adder.
`timescale 1ns/1ps
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_a_q, shift_a_d;
   logic [WIDTH-1:0] shift_b_q, shift_b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s;
   logic             fa_c;
   logic             last_bit;

   full_adder u_fa (
      .a    (shift_a_q[0]),
      .b    (shift_b_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: accept in IDLE, leave RUN after the MSB, DONE lasts one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_valid) state_d = ST_RUN;
         ST_RUN:  if (last_bit)    state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from state only, so no input reaches an output combinationally.
   always_comb begin
      start_ready = (state_q == ST_IDLE);
      busy        = (state_q != ST_IDLE);
      done        = (state_q == ST_DONE);
   end

   // Datapath registers; reset clears partial results so an aborted add leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a_q <= '0;
         shift_b_q <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         shift_a_q <= shift_a_d;
         shift_b_q <= shift_b_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         cnt_q     <= cnt_d;
      end
   end

   // Datapath next values: load on accept, shift one bit per RUN cycle, publish on the MSB.
   always_comb begin
      shift_a_d = shift_a_q;
      shift_b_d = shift_b_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      cnt_d     = cnt_q;
      acc_shift = acc_q >> 1;
      acc_shift[WIDTH-1] = fa_s;
      case (state_q)
         ST_IDLE: begin
            if (start_valid) begin
               shift_a_d = a;
               shift_b_d = b;
               carry_d   = cin;
               cnt_d     = '0;
            end
         end
         ST_RUN: begin
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            acc_d     = acc_shift;
            carry_d   = fa_c;
            if (last_bit) begin
               // Counter parks at WIDTH-1 instead of wrapping; the next accept clears it.
               sum_d  = acc_shift;
               cout_d = fa_c;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// compared against plain integer addition, for WIDTH=8 and WIDTH=1.
`timescale 1ns/1ps
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       sv8 = 1'b0;
   logic       sr8;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       ci8 = 1'b0;
   logic [7:0] sum8;
   logic       cout8;
   logic       done8;
   logic       busy8;

   logic       sv1 = 1'b0;
   logic       sr1;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       ci1 = 1'b0;
   logic [0:0] sum1;
   logic       cout1;
   logic       done1;
   logic       busy1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
      .a(a8), .b(b8), .cin(ci8), .sum(sum8), .cout(cout8),
      .done(done8), .busy(busy8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
      .a(a1), .b(b1), .cin(ci1), .sum(sum1), .cout(cout1),
      .done(done1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=8 operation from accept to return to IDLE, with exact done timing.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input bit hold, input logic [7:0] ha, input logic [7:0] hb);
      logic [8:0] ref_v;
      logic [7:0] prev_sum;
      logic       prev_cout;
      ref_v     = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      prev_sum  = sum8;
      prev_cout = cout8;
      check("ready_before_accept", sr8, 1'b1);
      a8 = a; b8 = b; ci8 = ci; sv8 = 1'b1;
      tick();
      if (hold) begin
         a8 = ha; b8 = hb; ci8 = ~ci;
      end else begin
         sv8 = 1'b0;
      end
      for (int i = 1; i <= 8; i++) begin
         if (i < 8) begin
            check("busy_run", busy8, 1'b1);
            check("ready_run", sr8, 1'b0);
            check("no_early_done", done8, 1'b0);
            check("sum_hold", sum8, prev_sum);
            check("cout_hold", cout8, prev_cout);
         end
         tick();
      end
      check("done_pulse", done8, 1'b1);
      check("busy_done", busy8, 1'b1);
      check("sum", sum8, ref_v[7:0]);
      check("cout", cout8, ref_v[8]);
      tick();
      check("done_width", done8, 1'b0);
      check("idle_ready", sr8, 1'b1);
      check("idle_busy", busy8, 1'b0);
      check("sum_after", sum8, ref_v[7:0]);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [1:0] ref1;

      // Reset held with start_valid asserted: nothing may be accepted.
      sv8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      sv1 = 1'b1;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_sum", sum8, 8'h00);
         check("rst_cout", cout8, 1'b0);
         check("rst_done", done8, 1'b0);
         check("rst_busy", busy8, 1'b0);
         check("rst_ready", sr8, 1'b1);
         check("rst_busy1", busy1, 1'b0);
         check("rst_ready1", sr1, 1'b1);
      end
      sv8 = 1'b0; sv1 = 1'b0;
      rst_n = 1'b1;
      tick();
      check("post_rst_busy", busy8, 1'b0);

      // Basic add and full carry ripple.
      op8(8'h3C, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
      op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 8'h00);

      // Busy ignore: new operands held during RUN, then accepted right after IDLE.
      op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hAA, 8'h55);
      check("hold_ignored_sum", sum8, 8'h30);
      op8(8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00);
      check("second_op_sum", sum8, 8'hFF);

      // Reset mid-run discards the partial result.
      a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; sv8 = 1'b1;
      tick();
      sv8 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("midrun_no_done", done8, 1'b0);
      end
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy8, 1'b0);
      check("midrst_sum", sum8, 8'h00);
      check("midrst_cout", cout8, 1'b0);
      check("midrst_ready", sr8, 1'b1);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("midrst_done", done8, 1'b0);
      end
      rst_n = 1'b1;
      tick();
      op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);

      // Random operands against integer addition.
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom_range(255));
         rb = 8'($urandom_range(255));
         rc = 1'($urandom_range(1));
         op8(ra, rb, rc, 1'b0, 8'h00, 8'h00);
      end

      // WIDTH=1 exhaustive: done arrives one edge after accept.
      for (int v = 0; v < 8; v++) begin
         a1 = 1'(v >> 2); b1 = 1'(v >> 1); ci1 = 1'(v);
         ref1 = 2'(a1) + 2'(b1) + 2'(ci1);
         check("w1_ready", sr1, 1'b1);
         sv1 = 1'b1;
         tick();
         sv1 = 1'b0;
         check("w1_busy_run", busy1, 1'b1);
         check("w1_no_done", done1, 1'b0);
         tick();
         check("w1_done", done1, 1'b1);
         check("w1_result", {cout1, sum1}, ref1);
         tick();
         check("w1_done_width", done1, 1'b0);
         check("w1_idle", sr1, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
